// File: rtl/rv32_branch_predictor_unit_pkg.sv
// Shared types for the rv32 branch predictor: word type, branch opcodes and
// the prediction-table entry layout.
package rv32_branch_predictor_unit_pkg;

    typedef logic [31:0] rv32_word;

    localparam rv32_word PC_STEP = 32'd4;

    // Unused code 3'b011 is deliberately left out; it resolves not-taken with no training.
    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_J    = 3'b010,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } branch_op_t;

    // Fields sized for the widest legal configuration (IDX_BITS >= 2, CNT_BITS <= 8);
    // narrower tags and counters are stored zero-extended.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        rv32_word    target;
        logic [7:0]  counter;
    } bp_entry_t;

endpackage

// File: rtl/rv32_branch_cond.sv
// Combinational branch condition evaluator: operands + opcode -> taken,
// with op_ok flagging a recognised opcode.
module rv32_branch_cond
    import rv32_branch_predictor_unit_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  branch_op_t  op,
    output logic        taken,
    output logic        op_ok
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (op1 == op2);
    assign lt  = ($signed(op1) < $signed(op2));
    assign ltu = (op1 < op2);

    always_comb begin
        taken = 1'b0;
        op_ok = 1'b1;
        case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BLT:  taken = lt;
            OP_BGE:  taken = !lt;
            OP_BLTU: taken = ltu;
            OP_BGEU: taken = !ltu;
            OP_J:    taken = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_branch_predictor_unit.sv
// Direct-mapped dynamic branch predictor with resolve, registered redirect and
// table training. Optional statistics counters are enabled by BRANCH_STATS_EN.
module rv32_branch_predictor_unit
    import rv32_branch_predictor_unit_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CNT_BITS  = 2,
    parameter int CNT_RESET = 1
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_flush,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_op1,
    input  logic [31:0] res_op2,
    input  branch_op_t  res_op,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
`ifdef BRANCH_STATS_EN
    input  logic        stat_clear,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [7:0] CNT_MAX   = 8'((1 << CNT_BITS) - 1);
    localparam logic [7:0] CNT_HALF  = 8'(1 << (CNT_BITS - 1));
    localparam logic [7:0] CNT_INIT  = 8'(CNT_RESET);
    localparam logic [7:0] CNT_ALLOC = (CNT_INIT >= CNT_MAX) ? CNT_MAX : CNT_INIT + 8'd1;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] c);
        return (c == 8'd0) ? 8'd0 : c - 8'd1;
    endfunction

    bp_entry_t table_q [ENTRIES];

    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] res_idx;
    logic [29:0]         pred_tag;
    logic [29:0]         res_tag;
    logic                unused_pred_lsbs;
    bp_entry_t           pred_e;
    bp_entry_t           res_e;
    bp_entry_t           upd_e;
    logic                upd_en;
    logic                pred_hit;
    logic                res_hit;
    logic                actual;
    logic                op_ok;
    logic                eff;
    logic                mispredict;

    assign pred_idx         = pred_pc[IDX_BITS+1:2];
    assign pred_tag         = 30'(pred_pc[31:IDX_BITS+2]);
    assign res_idx          = res_pc[IDX_BITS+1:2];
    assign res_tag          = 30'(res_pc[31:IDX_BITS+2]);
    assign unused_pred_lsbs = ^pred_pc[1:0];

    // Fetch-side lookup: reads the current table contents, so a same-cycle
    // update to this index is only visible from the next cycle.
    assign pred_e      = table_q[pred_idx];
    assign pred_hit    = pred_e.valid && (pred_e.tag == pred_tag);
    assign pred_taken  = pred_hit && (pred_e.counter >= CNT_HALF);
    assign pred_target = pred_taken ? pred_e.target : 32'd0;

    rv32_branch_cond u_cond (
        .op1   (res_op1),
        .op2   (res_op2),
        .op    (res_op),
        .taken (actual),
        .op_ok (op_ok)
    );

    assign eff        = res_valid && !res_flush;
    assign mispredict = (actual != res_pred_taken) || (actual && (res_pred_target != res_target));
    assign res_e      = table_q[res_idx];
    assign res_hit    = res_e.valid && (res_e.tag == res_tag);

    always_comb begin
        upd_en = 1'b0;
        upd_e  = res_e;
        if (eff && op_ok) begin
            if (res_hit) begin
                upd_en        = 1'b1;
                upd_e.counter = actual ? sat_inc(res_e.counter) : sat_dec(res_e.counter);
                if (actual) begin
                    upd_e.target = res_target;
                end
            end else if (actual) begin
                upd_en        = 1'b1;
                upd_e.valid   = 1'b1;
                upd_e.tag     = res_tag;
                upd_e.target  = res_target;
                upd_e.counter = CNT_ALLOC;
            end
        end
    end

    // Tags and targets carry no reset; only valid and counter are cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid   <= 1'b0;
                table_q[i].counter <= CNT_INIT;
            end
        end else if (upd_en) begin
            table_q[res_idx] <= upd_e;
        end
    end

    // Redirect stage: one cycle after the resolve.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= eff && mispredict;
            if (eff) begin
                redirect_pc <= actual ? res_target : res_pc + PC_STEP;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (stat_clear) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (eff) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32_branch_predictor_unit.sv
// Self-checking bench for rv32_branch_predictor_unit: directed scenarios plus
// randomized resolves against a behavioural table model.
module tb_rv32_branch_predictor_unit;
    import rv32_branch_predictor_unit_pkg::*;

    localparam int ENTRIES   = 64;
    localparam int CNT_MAX   = 3;
    localparam int CNT_RESET = 1;

    logic       clk = 1'b0;
    logic       resetn;
    rv32_word   pred_pc;
    logic       pred_taken;
    rv32_word   pred_target;
    logic       res_valid;
    logic       res_flush;
    rv32_word   res_pc;
    rv32_word   res_op1;
    rv32_word   res_op2;
    branch_op_t res_op;
    rv32_word   res_target;
    logic       res_pred_taken;
    rv32_word   res_pred_target;
    logic       redirect_valid;
    rv32_word   redirect_pc;
`ifdef BRANCH_STATS_EN
    logic       stat_clear;
    rv32_word   stat_branches;
    rv32_word   stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    bit          m_valid [ENTRIES];
    rv32_word    m_tag   [ENTRIES];
    rv32_word    m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic        exp_rv;
    rv32_word    exp_rpc;
    int unsigned exp_br;
    int unsigned exp_mp;

    rv32_branch_predictor_unit #(.ENTRIES(ENTRIES), .CNT_BITS(2), .CNT_RESET(CNT_RESET)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_flush       (res_flush),
        .res_pc          (res_pc),
        .res_op1         (res_op1),
        .res_op2         (res_op2),
        .res_op          (res_op),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
`ifdef BRANCH_STATS_EN
        .stat_clear      (stat_clear),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = CNT_RESET;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        exp_rv  = 1'b0;
        exp_rpc = '0;
        exp_br  = 0;
        exp_mp  = 0;
    endfunction

    function automatic bit model_cond(input branch_op_t op, input rv32_word a, input rv32_word b,
                                      output bit ok);
        ok = 1'b1;
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) < $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            OP_BLTU: return a < b;
            OP_BGEU: return a >= b;
            OP_J:    return 1'b1;
            default: begin ok = 1'b0; return 1'b0; end
        endcase
    endfunction

    function automatic void model_pred(input rv32_word pc, output bit t, output rv32_word tg);
        int       idx;
        bit       hit;
        idx = int'((pc / 4) % ENTRIES);
        hit = m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES));
        t   = hit && (m_cnt[idx] >= (CNT_MAX + 1) / 2);
        tg  = t ? m_tgt[idx] : 32'd0;
    endfunction

    function automatic void model_resolve();
        bit       actual;
        bit       ok;
        bit       mis;
        bit       hit;
        int       idx;
        rv32_word tag;
        if (res_valid && !res_flush) begin
            actual  = model_cond(res_op, res_op1, res_op2, ok);
            mis     = (actual != res_pred_taken) || (actual && res_pred_target != res_target);
            exp_rv  = mis;
            exp_rpc = actual ? res_target : res_pc + 32'd4;
            exp_br++;
            if (mis) exp_mp++;
            idx = int'((res_pc / 4) % ENTRIES);
            tag = res_pc / (4 * ENTRIES);
            hit = m_valid[idx] && (m_tag[idx] == tag);
            if (ok && hit) begin
                m_cnt[idx] = actual ? ((m_cnt[idx] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[idx] + 1)
                                    : ((m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1);
                if (actual) m_tgt[idx] = res_target;
            end else if (ok && actual) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_tgt[idx]   = res_target;
                m_cnt[idx]   = (CNT_RESET + 1 > CNT_MAX) ? CNT_MAX : CNT_RESET + 1;
            end
        end else begin
            exp_rv = 1'b0;
        end
`ifdef BRANCH_STATS_EN
        if (stat_clear) begin
            exp_br = 0;
            exp_mp = 0;
        end
`endif
    endfunction

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic apply(input rv32_word pc, input branch_op_t op, input rv32_word a, input rv32_word b,
                         input rv32_word tgt, input logic pt, input rv32_word ptgt,
                         input logic v, input logic f);
        res_pc          = pc;
        res_op          = op;
        res_op1         = a;
        res_op2         = b;
        res_target      = tgt;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
        res_valid       = v;
        res_flush       = f;
        pred_pc         = pc;
    endtask

    task automatic step();
        model_resolve();
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res_flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        apply(32'h100, OP_BEQ, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        stat_clear = 1'b0;
`endif
        model_reset();
        #13;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_pred: got taken=%0b target=%h, want 0/00000000", pred_taken, pred_target);
        end
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_redirect: got %0b/%h, want 0/00000000", redirect_valid, redirect_pc);
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_branches, stat_mispredicts);
        end
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_training();
        apply(32'h100, OP_BEQ, 5, 5, 32'h200, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            errors++;
            $display("FAIL beq_redirect: got %0b/%h, want 1/00000200", redirect_valid, redirect_pc);
        end
        pred_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL beq_alloc_pred: got %0b/%h, want 1/00000200", pred_taken, pred_target);
        end
    endtask

    task automatic test_signed();
        apply(32'h300, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin
            errors++;
            $display("FAIL blt_signed: got %0b/%h, want 1/00000400", redirect_valid, redirect_pc);
        end
        apply(32'h500, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h600, 1'b1, 32'h600, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h504) begin
            errors++;
            $display("FAIL bltu_unsigned: got %0b/%h, want 1/00000504", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_saturation();
        bit       et;
        rv32_word etg;
        apply(32'h100, OP_J, 0, 0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL correct_pred_no_redirect: got %0b, want 0", redirect_valid);
        end
        for (int k = 0; k < 5; k++) begin
            model_pred(32'h100, et, etg);
            apply(32'h100, OP_BNE, 7, 7, 32'h200, et, etg, 1'b1, 1'b0);
            step();
            checks++;
            if (redirect_valid !== exp_rv || redirect_pc !== exp_rpc) begin
                errors++;
                $display("FAIL sat_redirect[%0d]: got %0b/%h, want %0b/%h", k, redirect_valid, redirect_pc, exp_rv, exp_rpc);
            end
            model_pred(32'h100, et, etg);
            checks++;
            if (pred_taken !== et || pred_target !== etg || (k >= 1 && pred_taken !== 1'b0)) begin
                errors++;
                $display("FAIL sat_pred[%0d]: got %0b/%h, want %0b/%h", k, pred_taken, pred_target, et, etg);
            end
        end
        // From a floor of 0, one taken update must stay below the taken threshold.
        apply(32'h100, OP_J, 0, 0, 32'h200, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL sat_floor: got taken=%0b, want 0", pred_taken);
        end
    endtask

    task automatic test_flush();
        rv32_word held;
        held = exp_rpc;
        apply(32'h700, OP_J, 0, 0, 32'h800, 1'b0, 0, 1'b1, 1'b1);
        step();
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== held) begin
            errors++;
            $display("FAIL flush_redirect: got %0b/%h, want 0/%h", redirect_valid, redirect_pc, held);
        end
        pred_pc = 32'h700;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            errors++;
            $display("FAIL flush_no_alloc: got %0b/%h, want 0/00000000", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias_and_edges();
        apply(32'h100, OP_J, 0, 0, 32'h240, 1'b0, 0, 1'b1, 1'b0);
        step();
        pred_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
            errors++;
            $display("FAIL alias_base: got %0b/%h, want 1/00000240", pred_taken, pred_target);
        end
        pred_pc = 32'h100 + 4 * ENTRIES;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
            errors++;
            $display("FAIL alias_miss: got %0b/%h, want 0/00000000", pred_taken, pred_target);
        end
        apply(32'hFFFF_FFFC, OP_BNE, 3, 3, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL pc_wrap: got %0b/%h, want 1/00000000", redirect_valid, redirect_pc);
        end
        // Unknown opcode: resolves not-taken and must leave the hit entry untouched.
        apply(32'h100, branch_op_t'(3'b011), 1, 1, 32'h240, 1'b1, 32'h240, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
            errors++;
            $display("FAIL bad_op_redirect: got %0b/%h, want 1/00000104", redirect_valid, redirect_pc);
        end
        pred_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
            errors++;
            $display("FAIL bad_op_no_train: got %0b/%h, want 1/00000240", pred_taken, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        apply(32'h900, OP_J, 0, 0, 32'hA00, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'hA00) begin
            errors++;
            $display("FAIL b2b_first: got %0b/%h, want 1/00000a00", redirect_valid, redirect_pc);
        end
        apply(32'h904, OP_J, 0, 0, 32'hB00, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'hB00) begin
            errors++;
            $display("FAIL b2b_second: got %0b/%h, want 1/00000b00", redirect_valid, redirect_pc);
        end
        step();
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'hB00) begin
            errors++;
            $display("FAIL b2b_idle_hold: got %0b/%h, want 0/00000b00", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_random();
        bit       et;
        rv32_word etg;
        rv32_word pc;
        rv32_word a;
        for (int n = 0; n < 400; n++) begin
            pc = 32'h1000 + 4 * $urandom_range(0, 3) + 4 * ENTRIES * $urandom_range(0, 1);
            a  = $urandom();
            model_pred(pc, et, etg);
            apply(pc, branch_op_t'(3'($urandom_range(0, 7))), a,
                  ($urandom_range(0, 2) == 0) ? a : $urandom(),
                  32'h2000 + 4 * $urandom_range(0, 3),
                  ($urandom_range(0, 1) == 1) ? et : 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? etg : 32'h2000 + 4 * $urandom_range(0, 3),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
            #1;
            checks++;
            if (pred_taken !== et || pred_target !== etg) begin
                errors++;
                $display("FAIL rand_pred[%0d] pc=%h: got %0b/%h, want %0b/%h", n, pc, pred_taken, pred_target, et, etg);
            end
            step();
            checks++;
            if (redirect_valid !== exp_rv || redirect_pc !== exp_rpc) begin
                errors++;
                $display("FAIL rand_redirect[%0d]: got %0b/%h, want %0b/%h", n, redirect_valid, redirect_pc, exp_rv, exp_rpc);
            end
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        checks++;
        if (stat_branches !== exp_br || stat_mispredicts !== exp_mp) begin
            errors++;
            $display("FAIL stats_count: got %0d/%0d, want %0d/%0d", stat_branches, stat_mispredicts, exp_br, exp_mp);
        end
        apply(32'hC00, OP_J, 0, 0, 32'hD00, 1'b0, 0, 1'b1, 1'b0);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        checks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d/%0d, want 0/0", stat_branches, stat_mispredicts);
        end
        apply(32'hC04, OP_J, 0, 0, 32'hD00, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
            errors++;
            $display("FAIL stats_after_clear: got %0d/%0d, want 1/1", stat_branches, stat_mispredicts);
        end
    endtask
`endif

    task automatic test_async_reset();
        apply(32'hA00, OP_J, 0, 0, 32'hC00, 1'b0, 0, 1'b1, 1'b0);
        step();
        checks++;
        if (redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: got %0b, want 1", redirect_valid);
        end
        apply(32'hA04, OP_J, 0, 0, 32'hC40, 1'b0, 0, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        model_reset();
        pred_pc = 32'hA00;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got rv=%0b rpc=%h taken=%0b, want 0/00000000/0", redirect_valid, redirect_pc, pred_taken);
        end
        @(posedge clk);
        #1;
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_pending_lost: got %0b, want 0", redirect_valid);
        end
        res_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: got rv=%0b taken=%0b, want 0/0", redirect_valid, pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_signed();
        test_saturation();
        test_flush();
        test_alias_and_edges();
        test_back_to_back();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
